gcd_reg_bank: RTL and testbench

- Parametrised multi-entry register bank that replaces the single 32-bit enable register in the GCD datapath.
- Holds DEPTH operand/result words of WIDTH bits, each with a valid flag.
- Supports write, atomic two-entry swap (the GCD A/B exchange), clear-all, and dual registered read ports with optional write-to-read bypass.
- Sits between the GCD controller and the subtract/compare datapath.

---
 rtl/gcd_pkg.sv | 13 +
 rtl/gcd_rb_read_port.sv | 61 ++++++
 rtl/gcd_reg_bank.sv | 121 ++++++++++++
 tb/tb_gcd_reg_bank.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/gcd_pkg.sv
// Shared types and constants for the GCD datapath register bank.
package gcd_pkg;

    localparam int unsigned GCD_W = 32;

    typedef enum logic [1:0] {
        OP_NOP   = 2'd0,
        OP_WRITE = 2'd1,
        OP_SWAP  = 2'd2,
        OP_CLEAR = 2'd3
    } op_t;

endpackage

// File: rtl/gcd_rb_read_port.sv
// One registered read port of the GCD register bank: range check, optional
// same-cycle bypass from the post-operation contents, and output register.
module gcd_rb_read_port
    import gcd_pkg::*;
#(
    parameter  int unsigned WIDTH  = GCD_W,
    parameter  int unsigned DEPTH  = 4,
    parameter  int unsigned BYPASS = 1,
    localparam int unsigned AW     = $clog2(DEPTH)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         rd_en,
    input  logic [AW-1:0]                rd_addr,
    input  logic [DEPTH-1:0][WIDTH-1:0]  cur_data,
    input  logic [DEPTH-1:0]             cur_vld,
    input  logic [DEPTH-1:0][WIDTH-1:0]  nxt_data,
    input  logic [DEPTH-1:0]             nxt_vld,
    output logic [WIDTH-1:0]             rd_data,
    output logic                         rd_vld,
    output logic                         addr_err_c
);

    localparam logic [AW:0] LIM = (AW+1)'(DEPTH);

    logic             addr_ok;
    logic [WIDTH-1:0] sel_data;
    logic             sel_vld;

    assign addr_ok    = ({1'b0, rd_addr} < LIM);
    assign addr_err_c = rd_en && !addr_ok;

    // Invalid or out-of-range entries always read as zero data.
    always_comb begin
        sel_data = '0;
        sel_vld  = 1'b0;
        if (addr_ok) begin
            if (BYPASS != 0) begin
                sel_vld  = nxt_vld[rd_addr];
                sel_data = nxt_data[rd_addr];
            end else begin
                sel_vld  = cur_vld[rd_addr];
                sel_data = cur_data[rd_addr];
            end
        end
        if (!sel_vld) begin
            sel_data = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_data <= '0;
            rd_vld  <= 1'b0;
        end else if (rd_en) begin
            rd_data <= sel_data;
            rd_vld  <= sel_vld;
        end
    end

endmodule

// File: rtl/gcd_reg_bank.sv
// Multi-entry operand/result register bank for the GCD datapath with
// write, atomic swap, clear-all and two registered read ports.
module gcd_reg_bank
    import gcd_pkg::*;
#(
    parameter  int unsigned WIDTH  = GCD_W,
    parameter  int unsigned DEPTH  = 4,
    parameter  int unsigned BYPASS = 1,
    localparam int unsigned AW     = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  op_t              op,
    input  logic [AW-1:0]    addr_x,
    input  logic [AW-1:0]    addr_y,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr_a,
    input  logic [AW-1:0]    rd_addr_b,
    output logic [WIDTH-1:0] rd_data_a,
    output logic [WIDTH-1:0] rd_data_b,
    output logic             rd_vld_a,
    output logic             rd_vld_b,
    output logic             rd_valid,
    output logic             err,
    input  logic             err_clr
);

    localparam logic [AW:0] LIM = (AW+1)'(DEPTH);

    logic [DEPTH-1:0][WIDTH-1:0] mem, mem_n;
    logic [DEPTH-1:0]            vld, vld_n;
    logic                        x_ok, y_ok;
    logic                        err_a_c, err_b_c, op_err_c;

    assign x_ok = ({1'b0, addr_x} < LIM);
    assign y_ok = ({1'b0, addr_y} < LIM);

    assign op_err_c = ((op == OP_WRITE) && !x_ok) ||
                      ((op == OP_SWAP) && !(x_ok && y_ok));

    // Post-operation contents; bad-address writes and swaps are dropped.
    always_comb begin
        mem_n = mem;
        vld_n = vld;
        case (op)
            OP_WRITE: begin
                if (x_ok) begin
                    mem_n[addr_x] = wr_data;
                    vld_n[addr_x] = 1'b1;
                end
            end
            OP_SWAP: begin
                if (x_ok && y_ok) begin
                    mem_n[addr_x] = mem[addr_y];
                    mem_n[addr_y] = mem[addr_x];
                    vld_n[addr_x] = vld[addr_y];
                    vld_n[addr_y] = vld[addr_x];
                end
            end
            OP_CLEAR: vld_n = '0;
            default:  ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            mem      <= '0;
            vld      <= '0;
            rd_valid <= 1'b0;
            err      <= 1'b0;
        end else begin
            mem      <= mem_n;
            vld      <= vld_n;
            rd_valid <= rd_en;
            // A new error in the same cycle as err_clr keeps err set.
            if (op_err_c || err_a_c || err_b_c) begin
                err <= 1'b1;
            end else if (err_clr) begin
                err <= 1'b0;
            end
        end
    end

    gcd_rb_read_port #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .BYPASS (BYPASS)
    ) u_port_a (
        .clk        (clk),
        .rst        (rst),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr_a),
        .cur_data   (mem),
        .cur_vld    (vld),
        .nxt_data   (mem_n),
        .nxt_vld    (vld_n),
        .rd_data    (rd_data_a),
        .rd_vld     (rd_vld_a),
        .addr_err_c (err_a_c)
    );

    gcd_rb_read_port #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .BYPASS (BYPASS)
    ) u_port_b (
        .clk        (clk),
        .rst        (rst),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr_b),
        .cur_data   (mem),
        .cur_vld    (vld),
        .nxt_data   (mem_n),
        .nxt_vld    (vld_n),
        .rd_data    (rd_data_b),
        .rd_vld     (rd_vld_b),
        .addr_err_c (err_b_c)
    );

endmodule

// File: tb/tb_gcd_reg_bank.sv
// Bench for gcd_reg_bank: a BYPASS=1 and a BYPASS=0 instance share stimulus
// and are checked every cycle against an array-based model of the bank.
module tb_gcd_reg_bank;
    import gcd_pkg::*;

    localparam int unsigned W  = 32;
    localparam int unsigned D  = 6;
    localparam int unsigned AW = 3;

    logic          clk = 1'b0;
    logic          rst;
    op_t           op;
    logic [AW-1:0] addr_x, addr_y, rd_addr_a, rd_addr_b;
    logic [W-1:0]  wr_data;
    logic          rd_en, err_clr;

    // Index 0: BYPASS=0 instance, index 1: BYPASS=1 instance.
    logic [W-1:0] da [2];
    logic [W-1:0] db [2];
    logic         va [2];
    logic         vb [2];
    logic         rv [2];
    logic         er [2];

    logic [W-1:0] m_data [D];
    logic         m_vld  [D];
    logic [W-1:0] e_da [2];
    logic [W-1:0] e_db [2];
    logic         e_va [2];
    logic         e_vb [2];
    logic         e_rv, e_err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    gcd_reg_bank #(.WIDTH(W), .DEPTH(D), .BYPASS(0)) u_nob (
        .clk(clk), .rst(rst), .op(op), .addr_x(addr_x), .addr_y(addr_y),
        .wr_data(wr_data), .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(da[0]), .rd_data_b(db[0]), .rd_vld_a(va[0]), .rd_vld_b(vb[0]),
        .rd_valid(rv[0]), .err(er[0]), .err_clr(err_clr)
    );

    gcd_reg_bank #(.WIDTH(W), .DEPTH(D), .BYPASS(1)) u_byp (
        .clk(clk), .rst(rst), .op(op), .addr_x(addr_x), .addr_y(addr_y),
        .wr_data(wr_data), .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(da[1]), .rd_data_b(db[1]), .rd_vld_a(va[1]), .rd_vld_b(vb[1]),
        .rd_valid(rv[1]), .err(er[1]), .err_clr(err_clr)
    );

    function automatic void chk32(string name, logic [W-1:0] act, logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void chk1(string name, logic act, logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference behaviour for one clock edge, using the inputs held before it.
    task automatic model_step();
        logic [W-1:0] pd [D];
        logic         pv [D];
        logic         ok_x, ok_y, ok_a, ok_b, ev;
        if (!rst) begin
            for (int i = 0; i < int'(D); i++) begin
                m_data[i] = '0;
                m_vld[i]  = 1'b0;
            end
            for (int b = 0; b < 2; b++) begin
                e_da[b] = '0; e_db[b] = '0; e_va[b] = 1'b0; e_vb[b] = 1'b0;
            end
            e_rv  = 1'b0;
            e_err = 1'b0;
            return;
        end
        pd   = m_data;
        pv   = m_vld;
        ok_x = addr_x < AW'(D);
        ok_y = addr_y < AW'(D);
        ok_a = rd_addr_a < AW'(D);
        ok_b = rd_addr_b < AW'(D);
        if (op == OP_WRITE && ok_x) begin
            m_data[addr_x] = wr_data;
            m_vld[addr_x]  = 1'b1;
        end else if (op == OP_SWAP && ok_x && ok_y) begin
            m_data[addr_x] = pd[addr_y];
            m_data[addr_y] = pd[addr_x];
            m_vld[addr_x]  = pv[addr_y];
            m_vld[addr_y]  = pv[addr_x];
        end else if (op == OP_CLEAR) begin
            for (int i = 0; i < int'(D); i++) m_vld[i] = 1'b0;
        end
        if (rd_en) begin
            // Non-bypass view sees pre-operation contents, bypass sees post.
            e_va[0] = ok_a && pv[rd_addr_a];
            e_vb[0] = ok_b && pv[rd_addr_b];
            e_da[0] = e_va[0] ? pd[rd_addr_a] : '0;
            e_db[0] = e_vb[0] ? pd[rd_addr_b] : '0;
            e_va[1] = ok_a && m_vld[rd_addr_a];
            e_vb[1] = ok_b && m_vld[rd_addr_b];
            e_da[1] = e_va[1] ? m_data[rd_addr_a] : '0;
            e_db[1] = e_vb[1] ? m_data[rd_addr_b] : '0;
        end
        e_rv = rd_en;
        ev = (op == OP_WRITE && !ok_x) || (op == OP_SWAP && !(ok_x && ok_y)) ||
             (rd_en && !(ok_a && ok_b));
        if (ev) e_err = 1'b1;
        else if (err_clr) e_err = 1'b0;
    endtask

    task automatic check_all();
        for (int b = 0; b < 2; b++) begin
            chk32($sformatf("rd_data_a[byp=%0d]", b), da[b], e_da[b]);
            chk32($sformatf("rd_data_b[byp=%0d]", b), db[b], e_db[b]);
            chk1($sformatf("rd_vld_a[byp=%0d]", b), va[b], e_va[b]);
            chk1($sformatf("rd_vld_b[byp=%0d]", b), vb[b], e_vb[b]);
            chk1($sformatf("rd_valid[byp=%0d]", b), rv[b], e_rv);
            chk1($sformatf("err[byp=%0d]", b), er[b], e_err);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic set_in(input op_t o, input int ax, input int ay, input logic [W-1:0] wd,
                          input logic re, input int ra, input int rb, input logic ec);
        op        = o;
        addr_x    = AW'(ax);
        addr_y    = AW'(ay);
        wr_data   = wd;
        rd_en     = re;
        rd_addr_a = AW'(ra);
        rd_addr_b = AW'(rb);
        err_clr   = ec;
    endtask

    initial begin
        rst = 1'b0;
        set_in(OP_WRITE, 1, 0, 32'h1234_5678, 1'b1, 0, 1, 1'b0);
        cycle();
        set_in(OP_NOP, 0, 0, '0, 1'b0, 0, 0, 1'b0);
        cycle();
        rst = 1'b1;

        // Reset state read-back
        set_in(OP_NOP, 0, 0, '0, 1'b1, 0, 3, 1'b0);
        cycle();
        chk1("t1_rd_valid", rv[1], 1'b1);
        chk32("t1_data_a", da[1], 32'h0);
        chk1("t1_vld_b", vb[1], 1'b0);
        chk1("t1_err", er[0], 1'b0);

        // Write, write, swap, read
        set_in(OP_WRITE, 0, 0, 32'h30, 1'b0, 0, 0, 1'b0); cycle();
        set_in(OP_WRITE, 1, 0, 32'h12, 1'b0, 0, 0, 1'b0); cycle();
        set_in(OP_SWAP, 0, 1, '0, 1'b0, 0, 0, 1'b0);      cycle();
        set_in(OP_NOP, 0, 0, '0, 1'b1, 0, 1, 1'b0);       cycle();
        chk32("t2_data_a", da[1], 32'h12);
        chk32("t2_data_b", db[0], 32'h30);
        chk1("t2_vld_a", va[0], 1'b1);

        // Same-cycle write and read of one address
        set_in(OP_WRITE, 2, 0, 32'hDEAD_BEEF, 1'b1, 2, 2, 1'b0); cycle();
        chk32("t3_byp_data", da[1], 32'hDEAD_BEEF);
        chk1("t3_byp_vld", va[1], 1'b1);
        chk32("t3_nob_data", da[0], 32'h0);
        chk1("t3_nob_vld", va[0], 1'b0);

        // Clear then rewrite
        set_in(OP_WRITE, 3, 0, 32'hA, 1'b0, 0, 0, 1'b0); cycle();
        set_in(OP_CLEAR, 0, 0, '0, 1'b0, 0, 0, 1'b0);    cycle();
        set_in(OP_NOP, 0, 0, '0, 1'b1, 0, 3, 1'b0);      cycle();
        chk32("t4_clr_data_b", db[1], 32'h0);
        chk1("t4_clr_vld_a", va[1], 1'b0);
        set_in(OP_WRITE, 3, 0, 32'h5, 1'b0, 0, 0, 1'b0); cycle();
        set_in(OP_NOP, 0, 0, '0, 1'b1, 3, 3, 1'b0);      cycle();
        chk32("t4_rewrite_data", da[0], 32'h5);
        chk1("t4_rewrite_vld", vb[0], 1'b1);

        // Address range errors
        set_in(OP_WRITE, 7, 0, 32'h77, 1'b0, 0, 0, 1'b0); cycle();
        chk1("t5_err_set", er[1], 1'b1);
        set_in(OP_NOP, 0, 0, '0, 1'b1, 6, 3, 1'b0);       cycle();
        chk32("t5_bad_rd_data", da[1], 32'h0);
        chk1("t5_bad_rd_vld", va[1], 1'b0);
        chk32("t5_good_rd_data", db[1], 32'h5);
        set_in(OP_NOP, 0, 0, '0, 1'b0, 0, 0, 1'b1);       cycle();
        chk1("t5_err_clr", er[0], 1'b0);
        set_in(OP_WRITE, 7, 0, 32'h77, 1'b0, 0, 0, 1'b1); cycle();
        chk1("t5_set_wins", er[0], 1'b1);

        // Reset on the edge after an accepted read
        set_in(OP_NOP, 0, 0, '0, 1'b1, 3, 1, 1'b1); cycle();
        rst = 1'b0;
        cycle();
        chk1("t6_rd_valid", rv[1], 1'b0);
        rst = 1'b1;
        set_in(OP_NOP, 0, 0, '0, 1'b1, 3, 1, 1'b0); cycle();
        chk32("t6_data_a", da[0], 32'h0);
        chk1("t6_vld_a", va[1], 1'b0);

        // Randomised traffic
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 199) != 0);
            set_in(op_t'($urandom_range(0, 3)),
                   int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                   W'($urandom),
                   ($urandom_range(0, 2) != 0),
                   int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                   ($urandom_range(0, 5) == 0));
            if ($urandom_range(0, 3) != 0) begin
                addr_x    = AW'($urandom_range(0, D - 1));
                addr_y    = AW'($urandom_range(0, D - 1));
                rd_addr_a = AW'($urandom_range(0, D - 1));
                rd_addr_b = AW'($urandom_range(0, D - 1));
            end
            if ($urandom_range(0, 7) == 0) rd_addr_a = addr_x;
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
